// File: rtl/sa_seq_ctrl.sv
// Tile sequencer for a systolic-array job: clears and runs the address generator,
// drains the array, and steps through tiles with a RUN watchdog and abort support.
module sa_seq_ctrl #(
    parameter int FEATURE_BITS = 4,
    parameter int M            = 9,
    parameter int TILE_BITS    = 6,
    parameter int DRAIN_CYC    = 2*M-1,
    parameter int WD_CYC       = M*M+8
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 job_valid,
    input  logic [TILE_BITS-1:0] job_tiles,
    output logic                 job_ready,
    input  logic                 abort,
    output logic                 ag_start,
    input  logic                 ag_done,
    output logic                 ag_clr_n,
    output logic                 sa_en,
    output logic [TILE_BITS-1:0] tile_idx,
    output logic                 busy,
    output logic                 job_done,
    output logic                 err
);

    // Watchdog is at least wide enough to span the full two-iterator feature space.
    localparam int WD_NEED = $clog2(WD_CYC + 1);
    localparam int WD_W    = (WD_NEED > 2*FEATURE_BITS+1) ? WD_NEED : 2*FEATURE_BITS+1;
    localparam int DR_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYC - 1);
    localparam logic [DR_W-1:0] DR_LOAD = DR_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE, S_ABORT
    } state_t;

    state_t               state, state_nxt;
    logic [TILE_BITS-1:0] tiles_left;
    logic [DR_W-1:0]      drain_cnt;
    logic [WD_W-1:0]      wd_cnt;
    logic                 wd_expire;
    logic                 last_tile;

    assign wd_expire = (wd_cnt == WD_LAST);
    assign last_tile = (tile_idx == tiles_left - TILE_BITS'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (job_valid) state_nxt = (job_tiles == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: state_nxt = abort ? S_ABORT : S_RUN;
            S_RUN: begin
                if (abort)          state_nxt = S_ABORT;
                else if (ag_done)   state_nxt = S_DRAIN;
                else if (wd_expire) state_nxt = S_DONE;
            end
            S_DRAIN: begin
                if (abort)                state_nxt = S_ABORT;
                else if (drain_cnt == '0) state_nxt = last_tile ? S_DONE : S_CLEAR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        job_ready = 1'b0;
        ag_clr_n  = 1'b1;
        ag_start  = 1'b0;
        sa_en     = 1'b0;
        job_done  = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  job_ready = 1'b1;
            S_CLEAR: ag_clr_n  = 1'b0;
            S_RUN: begin
                ag_start = 1'b1;
                sa_en    = 1'b1;
            end
            S_DRAIN: sa_en     = 1'b1;
            S_DONE:  job_done  = 1'b1;
            S_ABORT: ag_clr_n  = 1'b0;
            default: ;
        endcase
    end

    // Watchdog sits at zero outside RUN, so it is always clear on RUN entry.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tiles_left <= '0;
            tile_idx   <= '0;
            drain_cnt  <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            wd_cnt <= (state == S_RUN) ? wd_cnt + WD_W'(1) : '0;

            if (state == S_IDLE && job_valid) begin
                tiles_left <= job_tiles;
                tile_idx   <= '0;
                err        <= 1'b0;
            end

            if (state == S_RUN && state_nxt == S_DRAIN)
                drain_cnt <= DR_LOAD;
            else if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DR_W'(1);

            if (state == S_RUN && !abort && !ag_done && wd_expire)
                err <= 1'b1;

            if (state_nxt == S_ABORT)
                tile_idx <= '0;
            else if (state == S_DRAIN && state_nxt == S_CLEAR)
                tile_idx <= tile_idx + TILE_BITS'(1);
        end
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl; an address-generator model counts RUN cycles and
// raises a sticky done at RUN cycle 81 when auto mode is enabled.
module tb_sa_seq_ctrl;

    localparam int TILE_BITS = 6;
    localparam int AG_LEN    = 81;

    logic                 sys_clk = 1'b0;
    logic                 reset_n;
    logic                 job_valid;
    logic [TILE_BITS-1:0] job_tiles;
    logic                 job_ready;
    logic                 abort;
    logic                 ag_start;
    logic                 ag_done;
    logic                 ag_clr_n;
    logic                 sa_en;
    logic [TILE_BITS-1:0] tile_idx;
    logic                 busy;
    logic                 job_done;
    logic                 err;

    int total = 0;
    int bad   = 0;

    logic ag_auto;
    logic ag_force;
    int   ag_cnt;

    sa_seq_ctrl #(.FEATURE_BITS(4), .M(9), .TILE_BITS(TILE_BITS)) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .job_valid(job_valid),
        .job_tiles(job_tiles),
        .job_ready(job_ready),
        .abort    (abort),
        .ag_start (ag_start),
        .ag_done  (ag_done),
        .ag_clr_n (ag_clr_n),
        .sa_en    (sa_en),
        .tile_idx (tile_idx),
        .busy     (busy),
        .job_done (job_done),
        .err      (err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (!ag_clr_n)     ag_cnt <= 0;
        else if (ag_start) ag_cnt <= ag_cnt + 1;
    end
    assign ag_done = ag_force | (ag_auto & (ag_cnt >= AG_LEN - 1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic bit in_win(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    initial begin
        int accepts;
        bit saw_done;

        reset_n   = 1'b0;
        job_valid = 1'b0;
        job_tiles = '0;
        abort     = 1'b0;
        ag_auto   = 1'b0;
        ag_force  = 1'b0;
        ag_cnt    = 0;

        // Reset state
        tick();
        check("rst job_ready", job_ready, 1);
        check("rst busy", busy, 0);
        check("rst ag_clr_n", ag_clr_n, 1);
        check("rst ag_start", ag_start, 0);
        check("rst sa_en", sa_en, 0);
        check("rst tile_idx", tile_idx, 0);
        check("rst err", err, 0);

        // Zero-tile job accepted on the first edge after reset release
        reset_n   = 1'b1;
        job_valid = 1'b1;
        job_tiles = '0;
        tick();
        job_valid = 1'b0;
        check("t0 c1 job_done", job_done, 1);
        check("t0 c1 busy", busy, 1);
        check("t0 c1 ag_clr_n", ag_clr_n, 1);
        check("t0 c1 ag_start", ag_start, 0);
        check("t0 c1 sa_en", sa_en, 0);
        check("t0 c1 job_ready", job_ready, 0);
        tick();
        check("t0 c2 job_ready", job_ready, 1);
        check("t0 c2 job_done", job_done, 0);

        // Three-tile job, full cycle-by-cycle timeline
        ag_auto   = 1'b1;
        job_valid = 1'b1;
        job_tiles = 6'd3;
        tick();
        job_valid = 1'b0;
        for (int c = 1; c <= 299; c++) begin
            bit run_e, drn_e, clr_e;
            int tile_e;
            run_e  = in_win(c, 2, 82) || in_win(c, 101, 181) || in_win(c, 200, 280);
            drn_e  = in_win(c, 83, 99) || in_win(c, 182, 198) || in_win(c, 281, 297);
            clr_e  = (c == 1) || (c == 100) || (c == 199);
            tile_e = (c < 100) ? 0 : (c < 199) ? 1 : 2;
            check($sformatf("t3 c%0d ag_start", c), ag_start, run_e);
            check($sformatf("t3 c%0d sa_en", c), sa_en, run_e | drn_e);
            check($sformatf("t3 c%0d ag_clr_n", c), ag_clr_n, !clr_e);
            check($sformatf("t3 c%0d job_done", c), job_done, c == 298);
            check($sformatf("t3 c%0d tile_idx", c), tile_idx, tile_e);
            check($sformatf("t3 c%0d busy", c), busy, c <= 298);
            if (c < 299) tick();
        end
        check("t3 end job_ready", job_ready, 1);

        // Watchdog: ag_done never arrives
        ag_auto   = 1'b0;
        job_valid = 1'b1;
        job_tiles = 6'd1;
        tick();
        job_valid = 1'b0;
        for (int c = 1; c <= 92; c++) begin
            check($sformatf("wd c%0d ag_start", c), ag_start, in_win(c, 2, 90));
            check($sformatf("wd c%0d job_done", c), job_done, c == 91);
            check($sformatf("wd c%0d err", c), err, c >= 91);
            if (c < 92) tick();
        end
        check("wd idle job_ready", job_ready, 1);
        // Next accepted job clears err; then abort it from CLEAR
        ag_auto   = 1'b1;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        check("wd next err", err, 0);
        check("wd next ag_clr_n", ag_clr_n, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wd abort ag_clr_n", ag_clr_n, 0);
        check("wd abort job_done", job_done, 0);
        tick();
        check("wd abort idle", job_ready, 1);

        // Abort in DRAIN of tile 1 together with a spurious ag_done
        saw_done  = 1'b0;
        job_valid = 1'b1;
        job_tiles = 6'd3;
        tick();
        job_valid = 1'b0;
        for (int c = 1; c < 185; c++) begin
            if (job_done) saw_done = 1'b1;
            tick();
        end
        check("ab c185 sa_en", sa_en, 1);
        check("ab c185 ag_start", ag_start, 0);
        check("ab c185 tile_idx", tile_idx, 1);
        abort    = 1'b1;
        ag_force = 1'b1;
        tick();
        abort    = 1'b0;
        ag_force = 1'b0;
        if (job_done) saw_done = 1'b1;
        check("ab c186 ag_clr_n", ag_clr_n, 0);
        check("ab c186 busy", busy, 1);
        check("ab c186 sa_en", sa_en, 0);
        check("ab c186 tile_idx", tile_idx, 0);
        tick();
        if (job_done) saw_done = 1'b1;
        check("ab c187 job_ready", job_ready, 1);
        check("ab c187 tile_idx", tile_idx, 0);
        check("ab no job_done", saw_done, 0);

        // job_valid held high: one acceptance per job, tile-count changes ignored
        accepts   = 0;
        job_valid = 1'b1;
        job_tiles = 6'd1;
        if (job_ready) accepts++;
        tick();
        for (int c = 1; c <= 100; c++) begin
            if (c == 5) job_tiles = 6'd5;
            if (job_ready) accepts++;
            if (c < 100) tick();
        end
        check("hold accepts", accepts, 1);
        check("hold c100 job_done", job_done, 1);
        tick();
        check("hold c101 job_ready", job_ready, 1);
        tick();
        check("hold c102 ag_clr_n", ag_clr_n, 0);
        check("hold c102 tile_idx", tile_idx, 0);
        job_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("hold end job_ready", job_ready, 1);

        // Asynchronous reset in the middle of RUN
        job_valid = 1'b1;
        job_tiles = 6'd2;
        tick();
        job_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("ar pre ag_start", ag_start, 1);
        reset_n = 1'b0;
        #1;
        check("ar job_ready", job_ready, 1);
        check("ar ag_start", ag_start, 0);
        check("ar sa_en", sa_en, 0);
        check("ar busy", busy, 0);
        check("ar ag_clr_n", ag_clr_n, 1);
        check("ar tile_idx", tile_idx, 0);
        check("ar err", err, 0);
        check("ar job_done", job_done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("ar post job_ready", job_ready, 1);
        check("ar post job_done", job_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
